// File: rtl/reg_file_arbiter_pkg.sv
// Shared types and width defaults for the register-file arbiter.
// Width defaults follow the register file's REG_LENGTH / ADDR_LEN_4 defines.
`ifndef REG_LENGTH
`define REG_LENGTH 32
`endif
`ifndef ADDR_LEN_4
`define ADDR_LEN_4 4
`endif

package reg_file_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W = `REG_LENGTH;
    localparam int unsigned DEF_ADDR_W = `ADDR_LEN_4;

    // Wait counter holds READ_LAT-1, so two bits cover READ_LAT 1..3.
    localparam int unsigned CNT_W = 2;

endpackage

// File: rtl/reg_file_arbiter_rr_arb2.sv
// Combinational two-input picker with one-hot grant; round-robin by default,
// fixed priority (req[0] first) when REG_FILE_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef REG_FILE_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_grant;

    always_comb begin
        gnt = '0;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie the requester that did not win last time goes first.
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end
`endif

endmodule

// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter/sequencer in front of the 16x32 register file.
// REG_FILE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin; READ_LAT legal range 1..3.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              rf_read_en,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LAT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              gnt_idx;
    logic              last_grant;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q0;
    logic [DATA_W-1:0] rdata_q1;

    logic              accept;
    logic              acc_idx;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    assign req = {req1_valid, req0_valid};

`ifdef REG_FILE_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= acc_idx;
        end
    end
`endif

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign req0_ready = (state == IDLE) && gnt[0];
    assign req1_ready = (state == IDLE) && gnt[1];
    assign accept     = req0_ready || req1_ready;
    assign acc_idx    = gnt[1];

    always_comb begin
        acc_write = req0_write;
        acc_addr  = req0_addr;
        acc_wdata = req0_wdata;
        if (acc_idx) begin
            acc_write = req1_write;
            acc_addr  = req1_addr;
            acc_wdata = req1_wdata;
        end
    end

    // The rf_* registers double as the command register: they are loaded on
    // accept, live for the single ISSUE cycle, and are cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            gnt_idx       <= 1'b0;
            rf_read_en    <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_addr       <= '0;
            rf_write_data <= '0;
            rvalid_q      <= '0;
            rdata_q0      <= '0;
            rdata_q1      <= '0;
        end else begin
            rf_read_en    <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_addr       <= '0;
            rf_write_data <= '0;
            rvalid_q      <= '0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rf_read_en    <= ~acc_write;
                        rf_write_en   <= acc_write;
                        rf_addr       <= acc_addr;
                        rf_write_data <= acc_wdata;
                        gnt_idx       <= acc_idx;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rf_write_en) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= LAT_M1;
                        state <= WAIT;
                        if (LAT_M1 == '0) begin
                            rvalid_q[gnt_idx] <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // rvalid is registered one cycle ahead so it lines up with cnt==0.
                    if (cnt == '0) begin
                        if (gnt_idx) begin
                            rdata_q1 <= rf_read_data;
                        end else begin
                            rdata_q0 <= rf_read_data;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            rvalid_q[gnt_idx] <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req0_rvalid = rvalid_q[0];
    assign req1_rvalid = rvalid_q[1];
    // In the pulse cycle the fresh read data is forwarded; afterwards the held copy.
    assign req0_rdata  = rvalid_q[0] ? rf_read_data : rdata_q0;
    assign req1_rdata  = rvalid_q[1] ? rf_read_data : rdata_q1;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: transaction-schedule reference model plus directed
// literal checks; REG_FILE_ARB_FIXED_PRIO_EN switches the expected arbitration rule.
module tb_reg_file_arbiter;

    localparam int RL_A = 1;
    localparam int RL_B = 3;
`ifdef REG_FILE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst;
    logic load_mem;

    logic        req0_valid, req0_write, req0_ready, req0_rvalid;
    logic [3:0]  req0_addr;
    logic [31:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_write, req1_ready, req1_rvalid;
    logic [3:0]  req1_addr;
    logic [31:0] req1_wdata, req1_rdata;
    logic        rf_read_en, rf_write_en;
    logic [3:0]  rf_addr;
    logic [31:0] rf_write_data, rf_read_data;

    logic        b_req0_valid, b_req0_write, b_req0_ready, b_req0_rvalid;
    logic [3:0]  b_req0_addr;
    logic [31:0] b_req0_wdata, b_req0_rdata;
    logic        b_req1_valid, b_req1_write, b_req1_ready, b_req1_rvalid;
    logic [3:0]  b_req1_addr;
    logic [31:0] b_req1_wdata, b_req1_rdata;
    logic        b_rf_read_en, b_rf_write_en;
    logic [3:0]  b_rf_addr;
    logic [31:0] b_rf_write_data, b_rf_read_data;

    int total = 0;
    int bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    reg_file_arbiter #(.DATA_W(32), .ADDR_W(4), .READ_LAT(RL_A)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .rf_read_en(rf_read_en), .rf_write_en(rf_write_en), .rf_addr(rf_addr),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    reg_file_arbiter #(.DATA_W(32), .ADDR_W(4), .READ_LAT(RL_B)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_write(b_req0_write), .req0_addr(b_req0_addr),
        .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready), .req0_rvalid(b_req0_rvalid),
        .req0_rdata(b_req0_rdata),
        .req1_valid(b_req1_valid), .req1_write(b_req1_write), .req1_addr(b_req1_addr),
        .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready), .req1_rvalid(b_req1_rvalid),
        .req1_rdata(b_req1_rdata),
        .rf_read_en(b_rf_read_en), .rf_write_en(b_rf_write_en), .rf_addr(b_rf_addr),
        .rf_write_data(b_rf_write_data), .rf_read_data(b_rf_read_data)
    );

    // Register file models: synchronous write, READ_LAT-deep read pipeline.
    logic [31:0] mem_a [16];
    logic [31:0] pipe_a [RL_A];
    logic [31:0] mem_b [16];
    logic [31:0] pipe_b [RL_B];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= 32'hC0DE0000 + 32'(i);
        end else if (rf_write_en) begin
            mem_a[rf_addr] <= rf_write_data;
        end
        pipe_a[0] <= rf_read_en ? mem_a[rf_addr] : 32'hDEADBEEF;
        for (int i = 1; i < RL_A; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign rf_read_data = pipe_a[RL_A-1];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= 32'hC0DE0000 + 32'(i);
        end else if (b_rf_write_en) begin
            mem_b[b_rf_addr] <= b_rf_write_data;
        end
        pipe_b[0] <= b_rf_read_en ? mem_b[b_rf_addr] : 32'hDEADBEEF;
        for (int i = 1; i < RL_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign b_rf_read_data = pipe_b[RL_B-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Reference model: each accepted operation books its issue cycle, its rvalid
    // cycle and the cycle the arbiter is free again; outputs follow that schedule.
    int          cyc     = 0;
    int          m_free  = 0;
    int          m_issue = -1;
    int          m_rv    = -1;
    int          m_last  = 1;
    int          win;
    logic        is_iss;
    logic        m_iw, m_rp;
    logic [3:0]  m_ia;
    logic [31:0] m_id, m_rdat, m_rd0, m_rd1;
    logic [31:0] ref_mem [16];

    always @(negedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = 32'hC0DE0000 + 32'(i);
        end
        if (rst) begin
            m_free  = 0;
            m_issue = -1;
            m_rv    = -1;
            m_last  = 1;
            m_rd0   = '0;
            m_rd1   = '0;
        end else begin
            win = -1;
            if (cyc >= m_free) begin
                if (req0_valid && req1_valid) win = (FIXED || m_last == 1) ? 0 : 1;
                else if (req0_valid) win = 0;
                else if (req1_valid) win = 1;
            end
            is_iss = (cyc == m_issue);
            if (cyc == m_rv) begin
                if (m_rp) m_rd1 = m_rdat;
                else      m_rd0 = m_rdat;
            end
            chk("req0_ready", 32'(req0_ready), 32'(win == 0));
            chk("req1_ready", 32'(req1_ready), 32'(win == 1));
            chk("rf_read_en", 32'(rf_read_en), 32'(is_iss && !m_iw));
            chk("rf_write_en", 32'(rf_write_en), 32'(is_iss && m_iw));
            chk("rf_addr", 32'(rf_addr), 32'(is_iss ? m_ia : 4'h0));
            if (!is_iss) chk("rf_write_data_idle", rf_write_data, 32'h0);
            else if (m_iw) chk("rf_write_data", rf_write_data, m_id);
            chk("req0_rvalid", 32'(req0_rvalid), 32'(cyc == m_rv && !m_rp));
            chk("req1_rvalid", 32'(req1_rvalid), 32'(cyc == m_rv && m_rp));
            chk("req0_rdata", req0_rdata, m_rd0);
            chk("req1_rdata", req1_rdata, m_rd1);
            if (win >= 0) begin
                m_last  = win;
                m_issue = cyc + 1;
                if (win == 0) begin
                    m_iw = req0_write; m_ia = req0_addr; m_id = req0_wdata;
                end else begin
                    m_iw = req1_write; m_ia = req1_addr; m_id = req1_wdata;
                end
                if (m_iw) begin
                    ref_mem[m_ia] = m_id;
                    m_free = cyc + 2;
                end else begin
                    m_rv   = cyc + 1 + RL_A;
                    m_rp   = (win == 1);
                    m_rdat = ref_mem[m_ia];
                    m_free = cyc + 2 + RL_A;
                end
            end
        end
        cyc++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int          n, got, ren_off, rv_off;
    int          g [4];
    logic [31:0] rv_data;
    logic        acc0, acc1;

    initial begin
        rst = 1'b1; load_mem = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        b_req0_valid = 0; b_req0_write = 0; b_req0_addr = '0; b_req0_wdata = '0;
        b_req1_valid = 0; b_req1_write = 0; b_req1_addr = '0; b_req1_wdata = '0;
        repeat (3) nxt();
        load_mem = 1'b0;
        nxt();
        rst = 1'b0;
        smp();
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_ren", 32'(rf_read_en), 32'd0);
        chk("rst_wen", 32'(rf_write_en), 32'd0);
        chk("rst_addr", 32'(rf_addr), 32'd0);
        chk("rst_wdata", rf_write_data, 32'd0);
        chk("rst_rvalid0", 32'(req0_rvalid), 32'd0);
        chk("rst_rdata0", req0_rdata, 32'd0);
        chk("rst_rdata1", req1_rdata, 32'd0);

        // Single write: ready in T, strobe in T+1
        nxt();
        req0_valid = 1; req0_write = 1; req0_addr = 4'h3; req0_wdata = 32'h43211234;
        smp();
        chk("wr3_ready", 32'(req0_ready), 32'd1);
        nxt();
        req0_valid = 0;
        smp();
        chk("wr3_wen", 32'(rf_write_en), 32'd1);
        chk("wr3_addr", 32'(rf_addr), 32'd3);
        chk("wr3_wdata", rf_write_data, 32'h43211234);

        // Write then read back the top address
        nxt();
        req0_valid = 1; req0_write = 1; req0_addr = 4'hF; req0_wdata = 32'hA5A5A5A5;
        smp();
        nxt();
        req0_valid = 0;
        nxt();
        req0_valid = 1; req0_write = 0;
        smp();
        chk("rdF_ready", 32'(req0_ready), 32'd1);
        nxt();
        req0_valid = 0;
        smp();
        chk("rdF_rvalid_early", 32'(req0_rvalid), 32'd0);
        nxt();
        smp();
        chk("rdF_rvalid", 32'(req0_rvalid), 32'd1);
        chk("rdF_rdata", req0_rdata, 32'hA5A5A5A5);

        // Reset during WAIT of a read
        nxt();
        req0_valid = 1; req0_write = 0; req0_addr = 4'h5;
        smp();
        nxt();
        req0_valid = 0;
        nxt();
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid0", 32'(req0_rvalid), 32'd0);
        chk("mid_rst_rvalid1", 32'(req1_rvalid), 32'd0);
        chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
        chk("mid_rst_ren", 32'(rf_read_en), 32'd0);
        chk("mid_rst_wen", 32'(rf_write_en), 32'd0);
        chk("mid_rst_addr", 32'(rf_addr), 32'd0);
        chk("mid_rst_rdata0", req0_rdata, 32'd0);
        smp();
        nxt();
        rst = 1'b0;
        nxt();
        req1_valid = 1; req1_write = 0; req1_addr = 4'h5;
        smp();
        chk("post_rst_ready1", 32'(req1_ready), 32'd1);
        nxt();
        req1_valid = 0;
        nxt();
        nxt();

        // Both requesters reading continuously
        req0_valid = 1; req0_write = 0; req0_addr = 4'h1;
        req1_valid = 1; req1_write = 0; req1_addr = 4'h2;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            smp();
            if (req0_valid && req0_ready) begin g[n] = 0; n++; end
            else if (req1_valid && req1_ready) begin g[n] = 1; n++; end
            nxt();
        end
        chk("alt_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) chk("alt_grant", 32'(g[i]), FIXED ? 32'd0 : 32'(i % 2));
        req0_valid = 0;
        got = 0;
        for (int k = 0; k < 12 && got == 0; k++) begin
            smp();
            if (req1_valid && req1_ready) got = 1;
            nxt();
        end
        chk("req1_after_drop", 32'(got), 32'd1);
        req1_valid = 0;
        repeat (6) nxt();
        smp();
        chk("alt_rdata0", req0_rdata, 32'hC0DE0001);
        chk("alt_rdata1", req1_rdata, 32'hC0DE0002);
        nxt();

        // Randomized traffic with occasional withdrawals
        for (int k = 0; k < 2000; k++) begin
            smp();
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            nxt();
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(9, 0) < 7);
                req0_write = ($urandom_range(1, 0) == 1);
                req0_addr  = 4'($urandom_range(15, 0));
                req0_wdata = $urandom;
            end else if ($urandom_range(9, 0) == 0) begin
                req0_valid = 0;
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(9, 0) < 7);
                req1_write = ($urandom_range(1, 0) == 1);
                req1_addr  = 4'($urandom_range(15, 0));
                req1_wdata = $urandom;
            end else if ($urandom_range(9, 0) == 0) begin
                req1_valid = 0;
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        repeat (8) nxt();

        // READ_LAT=3 instance: latency and ready held low while busy
        b_req0_valid = 1; b_req0_write = 0; b_req0_addr = 4'h0;
        smp();
        chk("b_accept", 32'(b_req0_ready), 32'd1);
        ren_off = 0; rv_off = 0; rv_data = '0;
        for (int off = 1; off <= 4; off++) begin
            nxt();
            smp();
            chk("b_busy_ready", 32'(b_req0_ready), 32'd0);
            if (b_rf_read_en) ren_off = off;
            if (b_req0_rvalid) begin
                rv_off  = off;
                rv_data = b_req0_rdata;
            end
        end
        nxt();
        b_req0_valid = 0;
        chk("b_ren_cycle", 32'(ren_off), 32'd1);
        chk("b_rvalid_cycle", 32'(rv_off), 32'd4);
        chk("b_rdata", rv_data, 32'hC0DE0000);
        repeat (2) nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
